io_debug_bridge: RTL and testbench

- Host-side initiator on the processor IO bus (io_write_en / io_read_en / io_address / io_write_data / io_read_data), driven by a byte stream from an external serial link.
- Lets a debug host peek and poke any memory-mapped peripheral register: LEDs, hex displays, GPIO, PS/2, frame-buffer base, UART.
- Sits beside the core as a second IO master. The top level muxes or arbitrates it against the core.

---
 rtl/io_debug_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_io_debug_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_debug_bridge.sv
// Serial-to-IO-bus debug master: peeks/pokes registers from a byte stream; read data captured READ_LATENCY clocks after strobe.
// tx held under tx_ready backpressure; rx has no backpressure (busy-time bytes pulse overrun). IO_BRIDGE_CHECKSUM_EN adds XOR check byte.
module io_debug_bridge #(
    parameter int RX_TIMEOUT   = 5000000,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        io_write_en,
    output logic        io_read_en,
    output logic [31:0] io_address,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    output logic        busy,
    output logic        overrun
);

    localparam logic [31:0] TIMEOUT_LAST = (RX_TIMEOUT == 0) ? 32'd0 : 32'(RX_TIMEOUT - 1);
    localparam logic [1:0]  LAT_LAST     = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef IO_BRIDGE_CHECKSUM_EN
        S_CHECK,
`endif
        S_BUS_WR,
        S_BUS_RD,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_wr;
    logic [1:0]  r_cnt;
    logic [31:0] r_idle;
    logic [1:0]  r_lat;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;
    logic [2:0]  r_resp_cnt;
    logic        r_overrun;
    logic        w_cmd_ok;
    logic        w_in_field;
    logic        w_timeout;
    logic        w_drop;
    logic        w_last_byte;

`ifdef IO_BRIDGE_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic        w_csum_ok;
    assign w_csum_ok  = (rx_data == r_csum);
    assign w_in_field = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CHECK);
`else
    assign w_in_field = (r_state == S_ADDR) || (r_state == S_DATA);
`endif

    assign w_cmd_ok    = (rx_data == 8'h01) || (rx_data == 8'h02);
    assign w_last_byte = rx_valid && (r_cnt == 2'd3);
    // An arriving byte always beats an expiring timeout.
    assign w_timeout   = (RX_TIMEOUT != 0) && w_in_field && !rx_valid && (r_idle == TIMEOUT_LAST);
    assign w_drop      = rx_valid && ((r_state == S_BUS_WR) || (r_state == S_BUS_RD) ||
                                      (r_state == S_RD_WAIT) || (r_state == S_RESP));

    assign io_address    = r_addr;
    assign io_write_data = r_wdata;
    assign tx_data       = r_resp[7:0];
    assign overrun       = r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        tx_valid    = 1'b0;
        io_write_en = 1'b0;
        io_read_en  = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (rx_valid) w_next = w_cmd_ok ? S_ADDR : S_RESP;
            S_ADDR: begin
                if (w_last_byte) begin
`ifdef IO_BRIDGE_CHECKSUM_EN
                    w_next = r_is_wr ? S_DATA : S_CHECK;
`else
                    w_next = r_is_wr ? S_DATA : S_BUS_RD;
`endif
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_last_byte) begin
`ifdef IO_BRIDGE_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_BUS_WR;
`endif
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
`ifdef IO_BRIDGE_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    if (!w_csum_ok) w_next = S_RESP;
                    else            w_next = r_is_wr ? S_BUS_WR : S_BUS_RD;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
`endif
            S_BUS_WR: begin
                io_write_en = 1'b1;
                w_next      = S_RESP;
            end
            S_BUS_RD: begin
                io_read_en = 1'b1;
                w_next     = S_RD_WAIT;
            end
            S_RD_WAIT: if (r_lat == LAT_LAST) w_next = S_RESP;
            S_RESP: begin
                tx_valid = 1'b1;
                if (tx_ready && (r_resp_cnt == 3'd1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_wr    <= 1'b0;
            r_cnt      <= 2'd0;
            r_idle     <= 32'd0;
            r_lat      <= 2'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_resp     <= 32'd0;
            r_resp_cnt <= 3'd0;
            r_overrun  <= 1'b0;
`ifdef IO_BRIDGE_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_overrun <= w_drop;
            r_idle    <= (w_in_field && !rx_valid) ? r_idle + 32'd1 : 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_is_wr <= (rx_data == 8'h01);
                        r_cnt   <= 2'd0;
`ifdef IO_BRIDGE_CHECKSUM_EN
                        r_csum  <= rx_data;
`endif
                        if (!w_cmd_ok) begin
                            r_resp     <= 32'h0000_00EE;
                            r_resp_cnt <= 3'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_addr[{r_cnt, 3'b000} +: 8] <= rx_data;
                        r_cnt                        <= r_cnt + 2'd1;
`ifdef IO_BRIDGE_CHECKSUM_EN
                        r_csum                       <= r_csum ^ rx_data;
`endif
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data;
                        r_cnt                         <= r_cnt + 2'd1;
`ifdef IO_BRIDGE_CHECKSUM_EN
                        r_csum                        <= r_csum ^ rx_data;
`endif
                    end
                end
`ifdef IO_BRIDGE_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_valid && !w_csum_ok) begin
                        r_resp     <= 32'h0000_00EE;
                        r_resp_cnt <= 3'd1;
                    end
                end
`endif
                S_BUS_WR: begin
                    r_resp     <= 32'h0000_00A5;
                    r_resp_cnt <= 3'd1;
                end
                S_BUS_RD: r_lat <= 2'd0;
                S_RD_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_resp     <= io_read_data;
                        r_resp_cnt <= 3'd4;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        r_resp     <= r_resp >> 8;
                        r_resp_cnt <= r_resp_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_debug_bridge.sv
// Scoreboarded bench for io_debug_bridge: directed commands, monitor pops expected bus/tx events.
module tb_io_debug_bridge;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        io_write_en;
    logic        io_read_en;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data = 32'h0;
    logic        busy;
    logic        overrun;

    logic [31:0] rd_value = 32'h0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          ov_cnt = 0;

    io_debug_bridge #(.RX_TIMEOUT(TO), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Registered read mux: data valid only in the cycle after the strobe.
    always @(posedge clk) io_read_data <= io_read_en ? rd_value : 32'hDEAD_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (overrun) ov_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) chk("unexpected_tx", {56'h0, tx_data}, 64'hFFFF);
                else chk("tx_byte", {56'h0, tx_data}, {56'h0, exp_tx.pop_front()});
            end
            if (io_write_en) begin
                if (exp_wr.size() == 0) chk("unexpected_wr", {io_address, io_write_data}, 64'hFFFF);
                else chk("wr_addr_data", {io_address, io_write_data}, exp_wr.pop_front());
            end
            if (io_read_en) begin
                if (exp_rd.size() == 0) chk("unexpected_rd", {32'h0, io_address}, 64'hFFFF);
                else chk("rd_addr", {32'h0, io_address}, {32'h0, exp_rd.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] x;
        x = 8'h01;
        send(8'h01);
        for (int i = 0; i < 4; i++) begin send(a[8*i +: 8]); x ^= a[8*i +: 8]; end
        for (int i = 0; i < 4; i++) begin send(d[8*i +: 8]); x ^= d[8*i +: 8]; end
`ifdef IO_BRIDGE_CHECKSUM_EN
        send(x);
`endif
    endtask

    task automatic send_rd(input logic [31:0] a);
        logic [7:0] x;
        x = 8'h02;
        send(8'h02);
        for (int i = 0; i < 4; i++) begin send(a[8*i +: 8]); x ^= a[8*i +: 8]; end
`ifdef IO_BRIDGE_CHECKSUM_EN
        send(x);
`endif
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (!busy) break;
            step();
        end
        chk(name, {63'h0, busy}, 64'h0);
    endtask

    task automatic wait_txvalid();
        for (int i = 0; i < 100; i++) begin
            if (tx_valid) break;
            step();
        end
        chk("tx_valid_wait", {63'h0, tx_valid}, 64'h1);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_outputs", {tx_valid, tx_data, io_write_en, io_read_en, busy, overrun},
            64'h0);
        chk("reset_bus", {io_address, io_write_data}, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Write 0x12345678 to 0x28.
        exp_wr.push_back({32'h28, 32'h1234_5678});
        exp_tx.push_back(8'hA5);
        send_wr(32'h28, 32'h1234_5678);
        wait_idle("write_idle");

        // Read 0x5C returning 0xCAFEBABE.
        rd_value = 32'hCAFE_BABE;
        exp_rd.push_back(32'h5C);
        exp_tx.push_back(8'hBE); exp_tx.push_back(8'hBA);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        send_rd(32'h5C);
        wait_idle("read_idle");

        // Read with tx held off for 10 clocks.
        rd_value = 32'h1122_3344;
        tx_ready = 1'b0;
        exp_rd.push_back(32'h30);
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h22); exp_tx.push_back(8'h11);
        send_rd(32'h30);
        wait_txvalid();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {63'h0, tx_valid}, 64'h1);
            chk("stall_data", {56'h0, tx_data}, 64'h44);
            step();
        end
        tx_ready = 1'b1;
        wait_idle("bp_idle");

        // Unknown command.
        exp_tx.push_back(8'hEE);
        send(8'h7F);
        wait_idle("badcmd_idle");

        // Abandoned command times out silently.
        send(8'h01);
        send(8'h00);
        chk("partial_busy", {63'h0, busy}, 64'h1);
        repeat (TO + 5) step();
        chk("timeout_idle", {63'h0, busy}, 64'h0);
        exp_wr.push_back({32'h44, 32'hDEAD_BEEF});
        exp_tx.push_back(8'hA5);
        send_wr(32'h44, 32'hDEAD_BEEF);
        wait_idle("after_timeout_idle");

        // Byte arriving during the response is dropped.
        rd_value = 32'hA1B2_C3D4;
        tx_ready = 1'b0;
        exp_rd.push_back(32'h8);
        exp_tx.push_back(8'hD4); exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'hB2); exp_tx.push_back(8'hA1);
        send_rd(32'h8);
        wait_txvalid();
        send(8'h55);
        step();
        chk("overrun_count", ov_cnt, 1);
        chk("ovr_data_held", {56'h0, tx_data}, 64'hD4);
        tx_ready = 1'b1;
        wait_idle("overrun_idle");
        chk("overrun_final", ov_cnt, 1);

        // Reset in the middle of the data phase.
        send(8'h01);
        send(8'h20); send(8'h00); send(8'h00); send(8'h00);
        send(8'h99); send(8'h88);
        chk("data_busy", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        #1;
        chk("midreset_outputs", {tx_valid, tx_data, io_write_en, io_read_en, busy, overrun},
            64'h0);
        chk("midreset_bus", {io_address, io_write_data}, 64'h0);
        step();
        reset = 1'b0;
        repeat (20) step();
        chk("post_reset_idle", {63'h0, busy}, 64'h0);

`ifdef IO_BRIDGE_CHECKSUM_EN
        rd_value = 32'h0BAD_F00D;
        exp_rd.push_back(32'h10);
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hAD); exp_tx.push_back(8'h0B);
        send(8'h02); send(8'h10); send(8'h00); send(8'h00); send(8'h00); send(8'h12);
        wait_idle("csum_ok_idle");
        exp_tx.push_back(8'hEE);
        send(8'h02); send(8'h10); send(8'h00); send(8'h00); send(8'h00); send(8'h13);
        wait_idle("csum_bad_idle");
`endif

        repeat (3) step();
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
